// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and flag controller for an async FIFO.
// Owns the read pointer. Compares it against the synchronized Gray write pointer to produce empty/level flags.
module rptr_empty_ctrl #(
  parameter int ASIZE         = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             ruflow_clr,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam logic [ASIZE:0] THR = (ASIZE+1)'(AEMPTY_THRESH);

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] rlevel_q, rlevel_d;
  logic           rempty_q, rempty_d;
  logic           raempty_q, raempty_d;
  logic           runderflow_q, runderflow_d;
  logic           rpop;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] diff;

  // XOR prefix from the MSB down recovers binary from Gray
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    rpop         = rinc & ~rempty_q;
    rbin_d       = rbin_q + {{ASIZE{1'b0}}, rpop};
    rptr_d       = (rbin_d >> 1) ^ rbin_d;
    wbin_s       = gray2bin(rq2_wptr);
    diff         = wbin_s - rbin_d;
    rempty_d     = (rptr_d == rq2_wptr);
    rlevel_d     = diff;
    raempty_d    = (diff <= THR);
    runderflow_d = runderflow_q;
    // an illegal pop on the same cycle as a clear must not be lost
    if (rinc & rempty_q)  runderflow_d = 1'b1;
    else if (ruflow_clr)  runderflow_d = 1'b0;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr      = rbin_q[ASIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed bench for rptr_empty_ctrl at ASIZE=4, AEMPTY_THRESH=2.
module tb_rptr_empty_ctrl;
  logic       rclk, rrst_n, rinc, ruflow_clr;
  logic [4:0] rq2_wptr;
  logic [3:0] raddr;
  logic [4:0] rptr, rlevel;
  logic       rempty, raempty, runderflow;

  int checks = 0, passed = 0;
  logic [4:0] exp_rbin, exp_w, prev_rptr;
  logic       mon_en = 1'b0;

  rptr_empty_ctrl #(.ASIZE(4), .AEMPTY_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .ruflow_clr(ruflow_clr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic step();
    @(posedge rclk); #1;
  endtask

  task automatic wr_step();
    exp_w = exp_w + 5'd1; rq2_wptr = b2g(exp_w); step();
  endtask

  task automatic pop_step();
    rinc = 1'b1; step(); rinc = 1'b0; exp_rbin = exp_rbin + 5'd1;
  endtask

  // every cycle: single-bit Gray steps and rptr tracking the expected binary pointer
  always @(negedge rclk) begin
    if (mon_en) begin
      checks++;
      if ($countones(rptr ^ prev_rptr) > 1 || rptr !== b2g(exp_rbin))
        $display("FAIL gray_mon: rptr=%b prev=%b required=%b", rptr, prev_rptr, b2g(exp_rbin));
      else passed++;
      prev_rptr = rptr;
    end
  end

  task automatic test_reset();
    exp_w = 5'd3; rq2_wptr = b2g(exp_w); step(); step();
    checks++; if (rlevel !== 5'd3) $display("FAIL pre_reset_level: got %0d want 3", rlevel); else passed++;
    pop_step();
    #2 rrst_n = 1'b0; #1;
    checks++; if (rempty !== 1'b1) $display("FAIL rst_empty: got %b want 1", rempty); else passed++;
    checks++; if (raempty !== 1'b1) $display("FAIL rst_aempty: got %b want 1", raempty); else passed++;
    checks++; if (rlevel !== 5'd0) $display("FAIL rst_level: got %0d want 0", rlevel); else passed++;
    checks++; if (rptr !== 5'd0) $display("FAIL rst_rptr: got %b want 0", rptr); else passed++;
    checks++; if (raddr !== 4'd0) $display("FAIL rst_raddr: got %0d want 0", raddr); else passed++;
    checks++; if (runderflow !== 1'b0) $display("FAIL rst_uflow: got %b want 0", runderflow); else passed++;
    exp_w = 5'd0; exp_rbin = 5'd0; rq2_wptr = 5'd0;
    @(negedge rclk); rrst_n = 1'b1;
    step();
    prev_rptr = rptr; mon_en = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 5; k++) begin
      wr_step();
      checks++; if (rlevel !== 5'(k)) $display("FAIL fill_level: got %0d want %0d", rlevel, k); else passed++;
    end
    checks++; if (rempty !== 1'b0) $display("FAIL fill_empty: got %b want 0", rempty); else passed++;
    checks++; if (raempty !== 1'b0) $display("FAIL fill_aempty: got %b want 0", raempty); else passed++;
    for (int k = 0; k < 5; k++) begin
      checks++; if (raddr !== 4'(k)) $display("FAIL pop_raddr: got %0d want %0d", raddr, k); else passed++;
      pop_step();
      checks++; if (rlevel !== 5'(4 - k)) $display("FAIL pop_level: got %0d want %0d", rlevel, 4 - k); else passed++;
      checks++; if (raempty !== (k >= 2)) $display("FAIL pop_aempty: got %b want %b", raempty, k >= 2); else passed++;
      checks++; if (rempty !== (k == 4)) $display("FAIL pop_empty: got %b want %b", rempty, k == 4); else passed++;
    end
  endtask

  task automatic test_underflow();
    rinc = 1'b1; step();
    checks++; if (raddr !== 4'd5) $display("FAIL uflow_hold: raddr=%0d want 5", raddr); else passed++;
    checks++; if (runderflow !== 1'b1) $display("FAIL uflow_set: got %b want 1", runderflow); else passed++;
    ruflow_clr = 1'b1; step();
    checks++; if (runderflow !== 1'b1) $display("FAIL uflow_setwins: got %b want 1", runderflow); else passed++;
    rinc = 1'b0; step();
    checks++; if (runderflow !== 1'b0) $display("FAIL uflow_clr: got %b want 0", runderflow); else passed++;
    ruflow_clr = 1'b0;
    checks++; if (rempty !== 1'b1) $display("FAIL uflow_empty: got %b want 1", rempty); else passed++;
  endtask

  task automatic test_wrap();
    logic [3:0] pa;
    logic       saw_wrap, saw_10000;
    saw_wrap = 1'b0; saw_10000 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      wr_step();
      checks++; if (rlevel !== 5'd1 || rempty !== 1'b0)
        $display("FAIL wrap_wr: level=%0d empty=%b want 1/0", rlevel, rempty); else passed++;
      pa = raddr;
      pop_step();
      checks++; if (rlevel !== 5'd0 || rempty !== 1'b1 || raddr !== exp_rbin[3:0])
        $display("FAIL wrap_rd: level=%0d empty=%b raddr=%0d want 0/1/%0d", rlevel, rempty, raddr, exp_rbin[3:0]); else passed++;
      if (pa == 4'd15 && raddr == 4'd0) saw_wrap = 1'b1;
      if (rptr == 5'b10000) saw_10000 = 1'b1;
    end
    checks++; if (!saw_wrap) $display("FAIL wrap_raddr: got no 15->0 want wrap"); else passed++;
    checks++; if (!saw_10000) $display("FAIL wrap_rptr: got no 10000 want seen"); else passed++;
    for (int k = 1; k <= 16; k++) begin
      wr_step();
      checks++; if (rlevel !== 5'(k)) $display("FAIL full_level: got %0d want %0d", rlevel, k); else passed++;
    end
    checks++; if (rempty !== 1'b0 || raempty !== 1'b0)
      $display("FAIL full_flags: empty=%b aempty=%b want 0/0", rempty, raempty); else passed++;
  endtask

  task automatic test_concurrent();
    for (int k = 0; k < 15; k++) pop_step();
    checks++; if (rlevel !== 5'd1) $display("FAIL conc_pre: got %0d want 1", rlevel); else passed++;
    rinc = 1'b1; wr_step(); rinc = 1'b0; exp_rbin = exp_rbin + 5'd1;
    checks++; if (rlevel !== 5'd1 || rempty !== 1'b0)
      $display("FAIL conc_level: level=%0d empty=%b want 1/0", rlevel, rempty); else passed++;
    pop_step();
    checks++; if (rlevel !== 5'd0 || rempty !== 1'b1 || raempty !== 1'b1)
      $display("FAIL conc_drain: level=%0d empty=%b aempty=%b want 0/1/1", rlevel, rempty, raempty); else passed++;
  endtask

  initial begin
    rrst_n = 1'b0; rinc = 1'b0; ruflow_clr = 1'b0; rq2_wptr = 5'd0;
    exp_rbin = 5'd0; exp_w = 5'd0; prev_rptr = 5'd0;
    #12 rrst_n = 1'b1;
    test_reset();
    test_fill();
    test_underflow();
    test_wrap();
    test_concurrent();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
